// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared constants and the buffered-result entry type
// for the register-file write-side controller.
package rf_wb_arbiter_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: bundles the WB, MUL/DIV, hazard-query and RF write-port
// signals around rf_wb_arbiter. The byp_* signals exist only when
// RF_WB_BYPASS_EN is defined.
interface rf_wb_arbiter_if #(parameter int N = 32);
  import rf_wb_arbiter_pkg::*;

  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic [N-1:0]     wb_data;
  logic             iss_valid;
  logic [REG_W-1:0] iss_rd;
  logic             ml_valid;
  logic [REG_W-1:0] ml_rd;
  logic [N-1:0]     ml_data;
  logic             ml_ready;
  logic [REG_W-1:0] q_rs1;
  logic [REG_W-1:0] q_rs2;
  logic [REG_W-1:0] q_rd;
  logic             busy_rs1;
  logic             busy_rs2;
  logic             busy_rd;
  logic             rf_we;
  logic [REG_W-1:0] rf_waddr;
  logic [N-1:0]     rf_wdata;
  logic             wb_hold;
  logic             wb_overrun;
`ifdef RF_WB_BYPASS_EN
  logic             byp_hit1;
  logic [N-1:0]     byp_data1;
  logic             byp_hit2;
  logic [N-1:0]     byp_data2;
`endif

  modport master (
    output wb_valid, wb_rd, wb_data, iss_valid, iss_rd,
    output ml_valid, ml_rd, ml_data, q_rs1, q_rs2, q_rd,
`ifdef RF_WB_BYPASS_EN
    input  byp_hit1, byp_data1, byp_hit2, byp_data2,
`endif
    input  ml_ready, busy_rs1, busy_rs2, busy_rd,
    input  rf_we, rf_waddr, rf_wdata, wb_hold, wb_overrun
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, iss_valid, iss_rd,
    input  ml_valid, ml_rd, ml_data, q_rs1, q_rs2, q_rd,
`ifdef RF_WB_BYPASS_EN
    output byp_hit1, byp_data1, byp_hit2, byp_data2,
`endif
    output ml_ready, busy_rs1, busy_rs2, busy_rd,
    output rf_we, rf_waddr, rf_wdata, wb_hold, wb_overrun
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: DEPTH-entry (power of two) buffer for long-latency results.
// Supports push and pop in the same cycle; head is visible the cycle after
// the entry was written.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; occupancy tracks both sides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; empty gates every use of the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges pipeline writeback and buffered MUL/DIV results onto
// the single RF write port, tracks pending long-latency destinations, and
// requests a WB bubble when a buffered result starves.
// Optional feature: define RF_WB_BYPASS_EN to add the byp_* decode bypass.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N            = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam int NREGS = 1 << REG_W;

  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic [N-1:0]     head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pipe_win;
  logic             pop;
  logic             rf_we;
  logic [REG_W-1:0] rf_waddr;
  logic [N-1:0]     rf_wdata;
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [CNT_W-1:0] starve_q;
  logic             hold_q;
  logic             overrun_q;

  assign pipe_win   = bus.wb_valid && (bus.wb_rd != REG_X0);
  assign pop        = !fifo_empty && !pipe_win;
  assign push_entry = '{rd: bus.ml_rd, data: bus.ml_data};
  assign head_data  = head.data;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.ml_valid && !fifo_full),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // One RF write per cycle: pipeline first, else the FIFO head; x0 never written.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (reset) begin
      rf_we = 1'b0;
    end else if (pipe_win) begin
      rf_we    = 1'b1;
      rf_waddr = bus.wb_rd;
      rf_wdata = bus.wb_data;
    end else if (!fifo_empty) begin
      rf_we    = (head.rd != REG_X0);
      rf_waddr = head.rd;
      rf_wdata = head_data;
    end
  end

  // Scoreboard next state: a drain clears, an issue sets, and the set wins a tie.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head.rd] = 1'b0;
    if (bus.iss_valid) pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending-destination register, discarded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Count how long the head has waited and hold WB until the cycle after it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      if (pop || fifo_empty)    starve_q <= '0;
      else if (starve_q < LIMIT) starve_q <= starve_q + 1'b1;
      hold_q <= pop ? 1'b0 : (hold_q || (starve_q >= LIMIT));
    end
  end

  // Sticky flag: the pipeline wrote while a bubble had been requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  overrun_q <= 1'b0;
    else if (pipe_win && hold_q) overrun_q <= 1'b1;
  end

  assign bus.ml_ready   = !fifo_full;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.wb_hold    = hold_q;
  assign bus.wb_overrun = overrun_q;
  assign bus.busy_rd    = pending_q[bus.q_rd];

`ifdef RF_WB_BYPASS_EN
  logic byp_hit1;
  logic byp_hit2;
  assign byp_hit1      = rf_we && (rf_waddr == bus.q_rs1);
  assign byp_hit2      = rf_we && (rf_waddr == bus.q_rs2);
  assign bus.byp_hit1  = byp_hit1;
  assign bus.byp_hit2  = byp_hit2;
  assign bus.byp_data1 = rf_wdata;
  assign bus.byp_data2 = rf_wdata;
  assign bus.busy_rs1  = pending_q[bus.q_rs1] && !byp_hit1;
  assign bus.busy_rs2  = pending_q[bus.q_rs2] && !byp_hit2;
`else
  assign bus.busy_rs1  = pending_q[bus.q_rs1];
  assign bus.busy_rs2  = pending_q[bus.q_rs2];
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
// (N=32, DEPTH=2, STARVE_LIMIT=4). Inputs change 1 time unit after a rising
// edge; outputs are compared 1 time unit later, well clear of the next edge.
module tb_rf_wb_arbiter;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  rf_wb_arbiter_if #(.N(32)) bus ();

  rf_wb_arbiter #(.N(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.wb_valid  = 1'b0; bus.wb_rd  = '0; bus.wb_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.ml_valid  = 1'b0; bus.ml_rd  = '0; bus.ml_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.q_rs1 = 5'd3; bus.q_rs2 = 5'd9; bus.q_rd = 5'd7;
    repeat (2) @(posedge clk);
    #2;
    n_compared++; if (bus.ml_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ml_ready: got %0h want 1", bus.ml_ready); end
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy_rs1: got %0h want 0", bus.busy_rs1); end
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rf_we: got %0h want 0", bus.rf_we); end
    n_compared++; if (bus.rf_waddr !== 5'd0) begin n_mismatched++; $display("[TB] FAIL reset_rf_waddr: got %0h want 0", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_rf_wdata: got %0h want 0", bus.rf_wdata); end
    n_compared++; if (bus.wb_hold !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wb_hold: got %0h want 0", bus.wb_hold); end
    n_compared++; if (bus.wb_overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wb_overrun: got %0h want 0", bus.wb_overrun); end
    tick();
    reset = 1'b0;
    #1;
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL release_rf_we: got %0h want 0", bus.rf_we); end
  endtask

  task automatic test_pipeline();
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    n_compared++; if (bus.rf_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pipe_we: got %0h want 1", bus.rf_we); end
    n_compared++; if (bus.rf_waddr !== 5'd5) begin n_mismatched++; $display("[TB] FAIL pipe_waddr: got %0h want 5", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL pipe_wdata: got %0h want deadbeef", bus.rf_wdata); end
    tick();
    bus.wb_rd = 5'd0; bus.wb_data = 32'h123;
    #1;
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pipe_x0_we: got %0h want 0", bus.rf_we); end
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    tick();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.q_rs1 = 5'd7; bus.q_rs2 = 5'd3; bus.q_rd = 5'd7;
    #1;
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sb_busy_before: got %0h want 0", bus.busy_rs1); end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    n_compared++; if (bus.busy_rs1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sb_busy_rs1_set: got %0h want 1", bus.busy_rs1); end
    n_compared++; if (bus.busy_rd !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sb_busy_rd_set: got %0h want 1", bus.busy_rd); end
    n_compared++; if (bus.busy_rs2 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sb_busy_rs2_other: got %0h want 0", bus.busy_rs2); end
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd7; bus.ml_data = 32'h1234;
    tick();
    bus.ml_valid = 1'b0;
    #1;
    n_compared++; if (bus.rf_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sb_drain_we: got %0h want 1", bus.rf_we); end
    n_compared++; if (bus.rf_waddr !== 5'd7) begin n_mismatched++; $display("[TB] FAIL sb_drain_waddr: got %0h want 7", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'h1234) begin n_mismatched++; $display("[TB] FAIL sb_drain_wdata: got %0h want 1234", bus.rf_wdata); end
`ifdef RF_WB_BYPASS_EN
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL byp_busy_forced: got %0h want 0", bus.busy_rs1); end
    n_compared++; if (bus.byp_hit1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL byp_hit1: got %0h want 1", bus.byp_hit1); end
    n_compared++; if (bus.byp_data1 !== 32'h1234) begin n_mismatched++; $display("[TB] FAIL byp_data1: got %0h want 1234", bus.byp_data1); end
    n_compared++; if (bus.byp_hit2 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL byp_hit2: got %0h want 0", bus.byp_hit2); end
`else
    n_compared++; if (bus.busy_rs1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sb_busy_during_drain: got %0h want 1", bus.busy_rs1); end
`endif
    tick();
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sb_busy_cleared: got %0h want 0", bus.busy_rs1); end
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sb_after_drain_we: got %0h want 0", bus.rf_we); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd7; bus.ml_data = 32'h55;
    tick();
    bus.ml_valid = 1'b0;
    #1;
    n_compared++; if (bus.rf_waddr !== 5'd7) begin n_mismatched++; $display("[TB] FAIL sb_tie_drain_waddr: got %0h want 7", bus.rf_waddr); end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    n_compared++; if (bus.busy_rs1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sb_set_wins: got %0h want 1", bus.busy_rs1); end
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd7; bus.ml_data = 32'h66;
    tick();
    bus.ml_valid = 1'b0;
    tick();
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL sb_final_clear: got %0h want 0", bus.busy_rs1); end
    idle();
  endtask

  task automatic test_x0_drop();
    tick();
    idle();
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd0; bus.ml_data = 32'hAAAA;
    tick();
    bus.ml_rd = 5'd4; bus.ml_data = 32'h44;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h99;
    #1;
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL x0_drop_we: got %0h want 0", bus.rf_we); end
    tick();
    idle();
    #1;
    n_compared++; if (bus.rf_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL x0_next_we: got %0h want 1", bus.rf_we); end
    n_compared++; if (bus.rf_waddr !== 5'd4) begin n_mismatched++; $display("[TB] FAIL x0_popped_waddr: got %0h want 4", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'h44) begin n_mismatched++; $display("[TB] FAIL x0_popped_wdata: got %0h want 44", bus.rf_wdata); end
    tick();
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL x0_empty_we: got %0h want 0", bus.rf_we); end
  endtask

  task automatic test_fifo_full();
    tick();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd1;
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd10; bus.ml_data = 32'hA0;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_ready_empty: got %0h want 1", bus.ml_ready); end
    tick();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd2;
    bus.ml_rd = 5'd11; bus.ml_data = 32'hB0;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_ready_one: got %0h want 1", bus.ml_ready); end
    n_compared++; if (bus.rf_waddr !== 5'd2) begin n_mismatched++; $display("[TB] FAIL full_pipe_priority: got %0h want 2", bus.rf_waddr); end
    tick();
    bus.ml_valid = 1'b0;
    bus.wb_rd = 5'd3; bus.wb_data = 32'd3;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_ready_low: got %0h want 0", bus.ml_ready); end
    n_compared++; if (bus.rf_waddr !== 5'd3) begin n_mismatched++; $display("[TB] FAIL full_pipe_waddr: got %0h want 3", bus.rf_waddr); end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_ready_same_cycle_pop: got %0h want 0", bus.ml_ready); end
    n_compared++; if (bus.rf_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_drain_we: got %0h want 1", bus.rf_we); end
    n_compared++; if (bus.rf_waddr !== 5'd10) begin n_mismatched++; $display("[TB] FAIL full_drain_waddr: got %0h want a", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'hA0) begin n_mismatched++; $display("[TB] FAIL full_drain_wdata: got %0h want a0", bus.rf_wdata); end
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd12; bus.wb_data = 32'd12;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL full_ready_after_pop: got %0h want 1", bus.ml_ready); end
    tick();
    idle();
    #1;
    n_compared++; if (bus.rf_waddr !== 5'd11) begin n_mismatched++; $display("[TB] FAIL full_second_waddr: got %0h want b", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'hB0) begin n_mismatched++; $display("[TB] FAIL full_second_wdata: got %0h want b0", bus.rf_wdata); end
    tick();
  endtask

  task automatic test_starvation();
    tick();
    idle();
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd20; bus.ml_data = 32'h200;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd1;
    tick();
    bus.ml_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_compared++; if (bus.wb_hold !== (i == 5)) begin n_mismatched++; $display("[TB] FAIL starve_hold_cycle%0d: got %0h want %0h", i, bus.wb_hold, (i == 5)); end
    end
    n_compared++; if (bus.wb_overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL starve_overrun_early: got %0h want 0", bus.wb_overrun); end
    tick();
    n_compared++; if (bus.wb_hold !== 1'b1) begin n_mismatched++; $display("[TB] FAIL starve_hold_stays: got %0h want 1", bus.wb_hold); end
    n_compared++; if (bus.wb_overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL starve_overrun_set: got %0h want 1", bus.wb_overrun); end
    bus.wb_valid = 1'b0;
    #1;
    n_compared++; if (bus.rf_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL starve_drain_we: got %0h want 1", bus.rf_we); end
    n_compared++; if (bus.rf_waddr !== 5'd20) begin n_mismatched++; $display("[TB] FAIL starve_drain_waddr: got %0h want 14", bus.rf_waddr); end
    n_compared++; if (bus.rf_wdata !== 32'h200) begin n_mismatched++; $display("[TB] FAIL starve_drain_wdata: got %0h want 200", bus.rf_wdata); end
    tick();
    n_compared++; if (bus.wb_hold !== 1'b0) begin n_mismatched++; $display("[TB] FAIL starve_hold_falls: got %0h want 0", bus.wb_hold); end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1;
    repeat (3) tick();
    n_compared++; if (bus.wb_overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL starve_overrun_sticky: got %0h want 1", bus.wb_overrun); end
    idle();
  endtask

  task automatic test_reset_mid();
    tick();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd1;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    bus.ml_valid = 1'b1; bus.ml_rd = 5'd3; bus.ml_data = 32'h33;
    tick();
    bus.iss_rd = 5'd9;
    bus.ml_rd = 5'd9; bus.ml_data = 32'h99;
    bus.wb_rd = 5'd2;
    tick();
    bus.iss_valid = 1'b0; bus.ml_valid = 1'b0;
    bus.q_rs1 = 5'd3; bus.q_rs2 = 5'd9; bus.q_rd = 5'd9;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_full: got %0h want 0", bus.ml_ready); end
    n_compared++; if (bus.busy_rs1 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_busy3: got %0h want 1", bus.busy_rs1); end
    n_compared++; if (bus.busy_rs2 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_busy9: got %0h want 1", bus.busy_rs2); end
    n_compared++; if (bus.busy_rd !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_busy_rd9: got %0h want 1", bus.busy_rd); end
    bus.wb_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_compared++; if (bus.ml_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_ml_ready: got %0h want 1", bus.ml_ready); end
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy_rs1: got %0h want 0", bus.busy_rs1); end
    n_compared++; if (bus.busy_rs2 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy_rs2: got %0h want 0", bus.busy_rs2); end
    n_compared++; if (bus.busy_rd !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy_rd: got %0h want 0", bus.busy_rd); end
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_rf_we: got %0h want 0", bus.rf_we); end
    n_compared++; if (bus.wb_overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_overrun: got %0h want 0", bus.wb_overrun); end
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_release_we: got %0h want 0", bus.rf_we); end
    tick();
    n_compared++; if (bus.rf_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_no_stale_we: got %0h want 0", bus.rf_we); end
    n_compared++; if (bus.busy_rs1 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_no_stale_busy: got %0h want 0", bus.busy_rs1); end
    n_compared++; if (bus.ml_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_ready_after: got %0h want 1", bus.ml_ready); end
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    $display("[TB] rf_wb_arbiter directed bench starting");
    test_reset();
    test_pipeline();
    test_scoreboard();
    test_x0_drop();
    test_fifo_full();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-side controller for the 32-entry integer register file. It merges single-cycle pipeline writeback with results from the long-latency M-extension multiply/divide unit onto the single RF write port, buffering the long-latency results in a small FIFO. It keeps a pending-destination scoreboard so the hazard unit can stall readers of registers whose long-latency result has not landed yet. It sits between the WB stage, the MUL/DIV unit and the RF write port (Write, Wdata, RegWrite).

## Interface
Parameters:
- N, 32, data width
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before a hold is requested (1–15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- wb_valid  in  1  pipeline writeback valid; never back-pressured
- wb_rd  in  5  pipeline destination
- wb_data  in  N  pipeline result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  5  its destination
- ml_valid  in  1  MUL/DIV result valid
- ml_rd  in  5  its destination
- ml_data  in  N  its result
- ml_ready  out  1  FIFO can accept (not full)
- q_rs1, q_rs2, q_rd  in  5 each  hazard-unit queries
- busy_rs1, busy_rs2, busy_rd  out  1 each  query register is pending
- rf_we  out  1  RF RegWrite
- rf_waddr  out  5  RF Write
- rf_wdata  out  N  RF Wdata
- wb_hold  out  1  request to hazard unit for a one-slot WB bubble
- wb_overrun  out  1  sticky error: wb_valid arrived while wb_hold was high

## Operation
- Slot free = !wb_valid || wb_rd==0.
- Pipeline has absolute priority. If wb_valid && wb_rd!=0, then rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
- Otherwise, if the FIFO is non-empty, the head drains: rf_we=1 (0 if head rd==0), addr and data come from the head, and the head pops.
- Writes to x0 are never issued, and rf_we stays 0. An x0 entry still pops.
- FIFO push when ml_valid && ml_ready. Push and pop may occur in the same cycle. A push while full cannot happen, because ml_ready=0.
- Scoreboard: pending[31:1], with pending[0] held at 0.
  - Set on iss_valid for iss_rd.
  - Cleared when a FIFO entry drains for that rd.
  - If set and clear hit the same rd in the same cycle, set wins.
- busy_x = pending[q_x], combinational. The hazard unit stalls any instruction whose source or destination is busy, so WAW ordering cannot arise.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head does not drain; resets to 0 on a pop.
  - When the count reaches STARVE_LIMIT, wb_hold=1, registered.
  - wb_hold stays high until the cycle after the head drains.
  - If wb_valid && wb_rd!=0 while wb_hold=1, the pipeline still wins and wb_overrun sets. It clears only on reset.

## Timing
- rf_we, rf_waddr and rf_wdata are combinational from the current inputs and the FIFO head. The RF commits at the next rising edge.
- FIFO latency: a result pushed at edge k is eligible to drain in cycle k+1. With free slots, ml_valid to RF commit is 1 cycle of buffering plus the RF edge.
- ml_ready depends only on the registered occupancy, so it does not reflect a same-cycle pop.
- wb_hold rises one cycle after the count reaches STARVE_LIMIT and falls one cycle after the pop.
- Reset values: FIFO empty, ml_ready=1, pending=0, busy_*=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_hold=0, wb_overrun=0, counter=0.
- Reset asserted mid-operation discards all buffered results and pending bits immediately.

## Configuration
- RF_WB_BYPASS_EN, when defined:
  - Adds outputs byp_hit1/byp_data1 and byp_hit2/byp_data2 (N bits).
  - byp_hitX=1 when rf_we && rf_waddr==q_rsX, with byp_data=rf_wdata. Decode reads the value being written this cycle.
  - A bypass hit also forces busy_rsX=0 for a draining pending register.
- Undefined: these ports are absent, and decode sees the new value one cycle later from the RF.

## Structure
- Shared package holds:
  - the register-index width constant (5) and the x0 index;
  - the FIFO entry typedef (rd, data).
- One sub-module is natural: rf_wb_fifo, a parameterised DEPTH FIFO with full/empty flags and same-cycle push/pop. Scoreboard, arbitration and starvation logic stay in the top module.

## Test plan
- **Pipeline only:** wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the same cycle.
- **x0 drop:** wb_rd=0 and FIFO head rd=0 → rf_we=0 and the FIFO still pops.
- **Scoreboard:** iss_valid with iss_rd=7, then q_rs1=7.
  - busy_rs1=1 from the next cycle.
  - ml result rd=7 pushed, then drains in an idle slot → busy_rs1=0 after the drain edge.
  - Same-cycle iss_rd=7 with drain of rd 7 → pending stays 1.
- **FIFO full:** two ml pushes while the pipeline writes every cycle → ml_ready=0. One idle slot → one pop, and ml_ready=1 next cycle.
- **Starvation:** STARVE_LIMIT=4, FIFO non-empty, continuous pipeline writes → wb_hold=1 on cycle 5. The bench then drops wb_valid → head drains, and wb_hold=0 the following cycle. wb_valid held high during the hold → wb_overrun=1 and stays 1 until reset.
- **Reset mid-operation:** FIFO holds 2 entries and pending bits for regs 3 and 9 are set; assert reset → ml_ready=1, busy_*=0, rf_we=0 immediately, and no stale write after release.
